// File: rtl/tt_lut_checker_if.sv
// Serial truth-table configuration channel for tt_lut_checker.
// The master side streams table bits while cfg_ready is high.
interface tt_lut_checker_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;

  modport master (
    output cfg_start,
    output cfg_valid,
    output cfg_bit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start,
    input  cfg_valid,
    input  cfg_bit,
    output cfg_ready
  );
endinterface

// File: rtl/tt_lut_checker.sv
// Programmable N-input truth-table cell with serial table load
// and a self-test sweep against an expected table.
module tt_lut_checker #(
  parameter int N_IN = 3,
  parameter logic [(1<<N_IN)-1:0] TT_INIT = 8'hCB
) (
  input  logic                clk,
  input  logic                rst_n,
  tt_lut_checker_if.slave     cfg,
  input  logic [N_IN-1:0]     in,
  output logic                out,
  input  logic                sweep_start,
  input  logic [(1<<N_IN)-1:0] exp_table,
  output logic                busy,
  output logic                sweep_done,
  output logic [N_IN:0]       mismatch_cnt,
  output logic                fail_flag,
  output logic [N_IN-1:0]     first_fail
);

  localparam int DEPTH = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  tt_q, tt_d;
  logic [DEPTH-1:0]  shadow_q, shadow_d;
  logic [DEPTH-1:0]  exp_q, exp_d;
  logic [N_IN-1:0]   ptr_q, ptr_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              fail_q, fail_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    tt_d     = tt_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    ff_d     = ff_q;
    out_d    = tt_q[in];
    unique case (state_q)
      IDLE: begin
        // Load takes priority over a coincident sweep request
        if (cfg.cfg_start) begin
          state_d  = LOAD;
          ptr_d    = '0;
          shadow_d = '0;
        end else if (sweep_start) begin
          state_d = SWEEP;
          exp_d   = exp_table;
          idx_d   = '0;
          cnt_d   = '0;
          fail_d  = 1'b0;
          ff_d    = '0;
        end
      end
      LOAD: begin
        if (cfg.cfg_valid) begin
          shadow_d[ptr_q] = cfg.cfg_bit;
          if (ptr_q == '1) begin
            tt_d    = shadow_d;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + N_IN'(1);
          end
        end
      end
      SWEEP: begin
        if (tt_q[idx_q] != exp_q[idx_q]) begin
          cnt_d  = cnt_q + (N_IN+1)'(1);
          fail_d = 1'b1;
          if (!fail_q) ff_d = idx_q;
        end
        if (idx_q == '1) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + N_IN'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == SWEEP);
    rdy_d  = (state_d == LOAD);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tt_q     <= TT_INIT;
      shadow_q <= '0;
      exp_q    <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= 1'b0;
      ff_q     <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tt_q     <= tt_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      ff_q     <= ff_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
    end
  end

  assign out           = out_q;
  assign busy          = busy_q;
  assign cfg.cfg_ready = rdy_q;
  assign sweep_done    = done_q;
  assign mismatch_cnt  = cnt_q;
  assign fail_flag     = fail_q;
  assign first_fail    = ff_q;

endmodule

// File: tb/tb_tt_lut_checker.sv
// Bench for tt_lut_checker: directed stimulus, sweep results
// checked by a scoreboard monitor on sweep_done.
module tb_tt_lut_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in = '0;
  logic       out;
  logic       sweep_start = 1'b0;
  logic [7:0] exp_table = '0;
  logic       busy;
  logic       sweep_done;
  logic [3:0] mismatch_cnt;
  logic       fail_flag;
  logic [2:0] first_fail;

  tt_lut_checker_if cfg_if ();

  tt_lut_checker #(.N_IN(3), .TT_INIT(8'hCB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_if),
    .in           (in),
    .out          (out),
    .sweep_start  (sweep_start),
    .exp_table    (exp_table),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .mismatch_cnt (mismatch_cnt),
    .fail_flag    (fail_flag),
    .first_fail   (first_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic       fail;
    logic [2:0] ff;
    int         t0;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   edge_cnt = 0;
  int   pushed   = 0;
  int   dones    = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && sweep_done) begin
      dones++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
        check("fail_flag", 32'(fail_flag), 32'(e.fail));
        check("first_fail", 32'(first_fail), 32'(e.ff));
        check("done_latency", edge_cnt - e.t0, 9);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [7:0] x, input logic [3:0] c,
                             input logic f, input logic [2:0] ff);
    exp_t s;
    sweep_start = 1'b1;
    exp_table   = x;
    step();
    s.cnt = c; s.fail = f; s.ff = ff; s.t0 = edge_cnt;
    sb_q.push_back(s);
    pushed++;
    sweep_start = 1'b0;
    exp_table   = 8'h00;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) step();
    check("sweep_timeout", sb_q.size(), 0);
    step();
  endtask

  task automatic cfg_begin();
    cfg_if.cfg_start = 1'b1;
    step();
    cfg_if.cfg_start = 1'b0;
    check("cfg_ready_load", 32'(cfg_if.cfg_ready), 1);
    check("busy_load", 32'(busy), 1);
  endtask

  task automatic send_bit(input logic b, input bit stall);
    if (stall) begin
      cfg_if.cfg_valid = 1'b0;
      step();
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_bit   = b;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_bit   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(sweep_done), 0);
    check("rst_cnt", 32'(mismatch_cnt), 0);
    check("rst_fail", 32'(fail_flag), 0);
    check("rst_ff", 32'(first_fail), 0);
    rst_n = 1'b1;

    // Evaluation of CB
    in = 3'b000; step();
    check("eval_000", 32'(out), 1);
    in = 3'b010; step();
    check("eval_010", 32'(out), 0);

    // Sweeps against CB
    start_sweep(8'hCB, 4'd0, 1'b0, 3'd0);
    check("busy_sweep", 32'(busy), 1);
    wait_sb();
    start_sweep(8'h34, 4'd8, 1'b1, 3'd0);
    wait_sb();
    start_sweep(8'hCA, 4'd1, 1'b1, 3'd0);
    wait_sb();
    start_sweep(8'hE3, 4'd2, 1'b1, 3'd3);
    wait_sb();

    // Load 96 with stalls; old table active until commit
    v = 8'h96;
    in = 3'b000;
    cfg_begin();
    for (int i = 0; i < 7; i++) send_bit(v[i], i[0]);
    check("old_tt_live", 32'(out), 1);
    send_bit(v[7], 1'b1);
    check("ready_commit", 32'(cfg_if.cfg_ready), 0);
    check("busy_commit", 32'(busy), 0);
    check("out_pre_commit", 32'(out), 1);
    step();
    check("out_post_commit", 32'(out), 0);
    in = 3'b111; step();
    check("eval96_111", 32'(out), 1);
    start_sweep(8'h96, 4'd0, 1'b0, 3'd0);
    wait_sb();

    // Reset in the middle of a load
    cfg_begin();
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_ready", 32'(cfg_if.cfg_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    in = 3'b011;
    step();
    check("midrst_eval011", 32'(out), 1);

    // Coincident cfg_start and sweep_start: load wins
    v = 8'hCB;
    cfg_if.cfg_start = 1'b1;
    sweep_start = 1'b1;
    exp_table = 8'h00;
    step();
    cfg_if.cfg_start = 1'b0;
    sweep_start = 1'b0;
    check("both_ready", 32'(cfg_if.cfg_ready), 1);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
    repeat (12) step();
    check("both_no_done", dones, pushed);
    in = 3'b010; step();
    check("both_eval010", 32'(out), 0);

    // sweep_start during SWEEP is ignored
    start_sweep(8'hCB, 4'd0, 1'b0, 3'd0);
    step(); step();
    sweep_start = 1'b1;
    exp_table = 8'h00;
    step();
    sweep_start = 1'b0;
    wait_sb();
    repeat (12) step();
    check("done_total", dones, pushed);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
